// File: rtl/if_stage.sv
// Instruction-fetch stage: local instruction memory plus the IF/ID pipeline register.
// Captures mem[PC], PC and PC+1 each edge, with stall, flush and a saturating fetch counter.
module if_stage #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              stall,
    input  logic              flush,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              valid,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] pc_next;

    // Memory is deliberately not reset; writes proceed regardless of stall/flush.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Write-first bypass: a same-edge write to the fetched address is what gets captured.
    always_comb begin
        rd_data = mem[PC];
        if (imem_we && (imem_waddr == PC)) begin
            rd_data = imem_wdata;
        end
    end

    assign pc_next = PC + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BUBBLE;
            instr       <= '0;
            pc_out      <= '0;
            pc_plus1    <= '0;
            fetch_count <= '0;
        end else if (flush) begin
            state    <= BUBBLE;
            instr    <= '0;
            pc_out   <= PC;
            pc_plus1 <= pc_next;
        end else if (!stall) begin
            state    <= RUN;
            instr    <= rd_data;
            pc_out   <= PC;
            pc_plus1 <= pc_next;
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

    assign valid = (state == RUN);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall, flush priority,
// write-first bypass, and counter saturation on a narrow-counter instance.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  PC = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;

    logic [31:0] instr, instr_s;
    logic [5:0]  pc_out, pc_out_s, pc_plus1, pc_plus1_s;
    logic        valid, valid_s;
    logic [15:0] fetch_count;
    logic [3:0]  fetch_count_s;

    int vectors = 0;
    int miscompares = 0;

    if_stage dut (
        .clk(clk), .rst(rst), .PC(PC), .stall(stall), .flush(flush),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .instr(instr), .pc_out(pc_out), .pc_plus1(pc_plus1),
        .valid(valid), .fetch_count(fetch_count)
    );

    if_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .PC(PC), .stall(stall), .flush(flush),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .instr(instr_s), .pc_out(pc_out_s), .pc_plus1(pc_plus1_s),
        .valid(valid_s), .fetch_count(fetch_count_s)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_instr,
                             input logic [5:0] e_pc, input logic [5:0] e_pc1,
                             input logic e_valid, input logic [15:0] e_cnt);
        check({tag, "/instr"}, 64'(instr), 64'(e_instr));
        check({tag, "/pc_out"}, 64'(pc_out), 64'(e_pc));
        check({tag, "/pc_plus1"}, 64'(pc_plus1), 64'(e_pc1));
        check({tag, "/valid"}, 64'(valid), 64'(e_valid));
        check({tag, "/count"}, 64'(fetch_count), 64'(e_cnt));
    endtask

    initial begin
        // Asynchronous reset from unknown state, checked before any clock edge.
        #2 rst = 1'b0;
        #1 check_all("reset_async", 32'h0, 6'd0, 6'd0, 1'b0, 16'd0);

        imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = 32'h2001_0005;
        step();
        imem_we = 1'b0;
        check_all("reset_hold", 32'h0, 6'd0, 6'd0, 1'b0, 16'd0);

        rst = 1'b1; PC = 6'd0;
        step();
        check_all("first_fetch", 32'h2001_0005, 6'd0, 6'd1, 1'b1, 16'd1);

        // Reset asserted mid-cycle with stall and flush active.
        #2 rst = 1'b0; stall = 1'b1; flush = 1'b1; PC = 6'd7;
        #1 check_all("reset_mid", 32'h0, 6'd0, 6'd0, 1'b0, 16'd0);
        step();
        check_all("reset_wins", 32'h0, 6'd0, 6'd0, 1'b0, 16'd0);
        stall = 1'b0; flush = 1'b0;

        for (int k = 0; k < 64; k++) begin
            imem_we = 1'b1; imem_waddr = 6'(k); imem_wdata = 32'h1000_0000 + 32'(k);
            step();
        end
        imem_we = 1'b0;
        check_all("preload_in_reset", 32'h0, 6'd0, 6'd0, 1'b0, 16'd0);
        check("sat_count_reset", 64'(fetch_count_s), 64'd0);

        rst = 1'b1;
        for (int i = 0; i < 65; i++) begin
            PC = 6'(i % 64);
            step();
            check_all("seq", 32'h1000_0000 + 32'(i % 64), 6'(i % 64), 6'((i + 1) % 64),
                      1'b1, 16'(i + 1));
            check("sat_count", 64'(fetch_count_s), 64'((i + 1) > 15 ? 15 : (i + 1)));
        end
        check("count_65", 64'(fetch_count), 64'd65);

        PC = 6'd5;
        step();
        check_all("pre_stall", 32'h1000_0005, 6'd5, 6'd6, 1'b1, 16'd66);
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            PC = 6'(6 + j);
            step();
            check_all("stall", 32'h1000_0005, 6'd5, 6'd6, 1'b1, 16'd66);
        end
        stall = 1'b0;
        step();
        check_all("stall_release", 32'h1000_0008, 6'd8, 6'd9, 1'b1, 16'd67);

        PC = 6'd9; stall = 1'b1; flush = 1'b1;
        step();
        check_all("flush_prio", 32'h0, 6'd9, 6'd10, 1'b0, 16'd67);
        stall = 1'b1; flush = 1'b0;
        step();
        check_all("bubble_stall", 32'h0, 6'd9, 6'd10, 1'b0, 16'd67);
        stall = 1'b0;
        step();
        check_all("post_flush", 32'h1000_0009, 6'd9, 6'd10, 1'b1, 16'd68);

        PC = 6'd63; flush = 1'b1;
        step();
        check_all("flush_wrap", 32'h0, 6'd63, 6'd0, 1'b0, 16'd68);
        flush = 1'b0;

        PC = 6'd12; imem_we = 1'b1; imem_waddr = 6'd12; imem_wdata = 32'hDEAD_BEEF;
        step();
        check_all("write_first", 32'hDEAD_BEEF, 6'd12, 6'd13, 1'b1, 16'd69);
        imem_we = 1'b0; PC = 6'd13;
        step();
        check_all("after_write", 32'h1000_000D, 6'd13, 6'd14, 1'b1, 16'd70);
        PC = 6'd12;
        step();
        check_all("reread", 32'hDEAD_BEEF, 6'd12, 6'd13, 1'b1, 16'd71);

        // Write under stall lands in memory while the register holds.
        stall = 1'b1; imem_we = 1'b1; imem_waddr = 6'd20; imem_wdata = 32'hCAFE_F00D; PC = 6'd20;
        step();
        check_all("write_stalled", 32'hDEAD_BEEF, 6'd12, 6'd13, 1'b1, 16'd71);
        stall = 1'b0; imem_we = 1'b0;
        step();
        check_all("read_stalled_write", 32'hCAFE_F00D, 6'd20, 6'd21, 1'b1, 16'd72);
        check("sat_count_hold", 64'(fetch_count_s), 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
